// File: rtl/wptr_full_sync.sv
// Async FIFO write side: binary/Gray write pointer, 2-flop read-pointer synchronizer, full and sticky overflow.
// Define FIFO_AFULL_EN to add the registered WAFULL (almost-full) output.
module wptr_full_sync #(
   parameter int unsigned ADDR_SIZE    = 4,
   parameter int unsigned AFULL_MARGIN = 2
) (
   input  logic                 WCLK,
   input  logic                 WRST_N,
   input  logic                 WINC,
   input  logic [ADDR_SIZE:0]   RPTR,
   output logic [ADDR_SIZE-1:0] WADDR,
   output logic [ADDR_SIZE:0]   WPTR,
   output logic                 WFULL,
   output logic                 WOVF
`ifdef FIFO_AFULL_EN
   ,
   output logic                 WAFULL
`endif
);

   localparam int unsigned PW = ADDR_SIZE + 1;

   logic [ADDR_SIZE:0] wq1_q, wq2_q;
   logic [ADDR_SIZE:0] wbin_q, wbin_d;
   logic [ADDR_SIZE:0] wptr_q, wgray_d;
   logic               wfull_q, wfull_d;
   logic               wovf_q, wovf_d;
   logic               winc_ok;

   always_comb begin
      winc_ok = WINC & ~wfull_q;
      wbin_d  = wbin_q + PW'(winc_ok);
      wgray_d = (wbin_d >> 1) ^ wbin_d;
      // Full when the write pointer is one lap ahead of the synchronized read pointer.
      wfull_d = (wgray_d == {~wq2_q[ADDR_SIZE:ADDR_SIZE-1], wq2_q[ADDR_SIZE-2:0]});
      wovf_d  = wovf_q | (WINC & wfull_q);
   end

   always_ff @(posedge WCLK or negedge WRST_N) begin
      if (!WRST_N) begin
         wq1_q   <= '0;
         wq2_q   <= '0;
         wbin_q  <= '0;
         wptr_q  <= '0;
         wfull_q <= 1'b0;
         wovf_q  <= 1'b0;
      end else begin
         wq1_q   <= RPTR;
         wq2_q   <= wq1_q;
         wbin_q  <= wbin_d;
         wptr_q  <= wgray_d;
         wfull_q <= wfull_d;
         wovf_q  <= wovf_d;
      end
   end

`ifdef FIFO_AFULL_EN
   localparam logic [ADDR_SIZE:0] AFULL_TH = PW'((2 ** ADDR_SIZE) - AFULL_MARGIN);

   logic [ADDR_SIZE:0] rbin_s;
   logic [ADDR_SIZE:0] used_d;
   logic               wafull_q, wafull_d;

   always_comb begin
      rbin_s = '0;
      // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
      for (int unsigned i = 0; i <= ADDR_SIZE; i++) begin
         rbin_s[i] = ^(wq2_q >> i);
      end
      used_d   = wbin_d - rbin_s;
      wafull_d = (used_d >= AFULL_TH);
   end

   always_ff @(posedge WCLK or negedge WRST_N) begin
      if (!WRST_N) begin
         wafull_q <= 1'b0;
      end else begin
         wafull_q <= wafull_d;
      end
   end

   assign WAFULL = wafull_q;
`endif

   assign WADDR = wbin_q[ADDR_SIZE-1:0];
   assign WPTR  = wptr_q;
   assign WFULL = wfull_q;
   assign WOVF  = wovf_q;

endmodule
